// File: rtl/trsig_pkg.sv
// trsig_pkg: shared types and constants for the traffic-signal conflict monitor.
//   aspect_e      : decoded per-approach lamp aspect (RED/YEL/GRN/BAD)
//   FC_*          : fault codes; lower value has higher priority
//   *_DEF         : default minimum dwell times (shared with the controller) and flash divider
package trsig_pkg;

   typedef enum logic [1:0] {
      ASP_RED = 2'd0,
      ASP_YEL = 2'd1,
      ASP_GRN = 2'd2,
      ASP_BAD = 2'd3
   } aspect_e;

   localparam logic [2:0] FC_NONE        = 3'd0;
   localparam logic [2:0] FC_CONFLICT    = 3'd1;
   localparam logic [2:0] FC_ILLEGAL_ASP = 3'd2;
   localparam logic [2:0] FC_BAD_SEQ     = 3'd3;
   localparam logic [2:0] FC_SHORT_YEL   = 3'd4;
   localparam logic [2:0] FC_SHORT_GRN   = 3'd5;

   localparam int unsigned MIN_GRN_CYC_DEF = 5;
   localparam int unsigned MIN_YEL_CYC_DEF = 3;
   localparam int unsigned FLASH_DIV_DEF   = 4;

   // Exactly one lit lamp gives a valid aspect; anything else is BAD.
   function automatic aspect_e decode_aspect(input logic red, input logic yel, input logic grn);
      aspect_e asp;
      case ({red, yel, grn})
         3'b100:  asp = ASP_RED;
         3'b010:  asp = ASP_YEL;
         3'b001:  asp = ASP_GRN;
         default: asp = ASP_BAD;
      endcase
      return asp;
   endfunction

   // Allowed steps: hold, GRN->YEL, YEL->RED, RED->GRN.
   function automatic logic legal_step(input aspect_e prev, input aspect_e cur);
      return (prev == cur) ||
             ((prev == ASP_GRN) && (cur == ASP_YEL)) ||
             ((prev == ASP_YEL) && (cur == ASP_RED)) ||
             ((prev == ASP_RED) && (cur == ASP_GRN));
   endfunction

endpackage

// File: rtl/trsig_aspect_chk.sv
// trsig_aspect_chk: per-approach aspect decode, history and dwell tracking.
//   clk, rst              : clock, synchronous active-high reset
//   vld_i                 : stage-1 lamp sample is valid this cycle
//   red_i, yel_i, grn_i   : stage-1 sampled lamps
//   aspect_c_o            : decoded aspect of the current sample (combinational)
//   bad_c_o               : current sample is BAD
//   illegal_seq_c_o       : illegal aspect change versus previous sample
//   short_yel_c_o         : YEL->RED with yellow dwell below minimum
//   short_grn_c_o         : GRN->YEL with green dwell below minimum
//   red_to_grn_c_o        : RED->GRN step on this sample
module trsig_aspect_chk
   import trsig_pkg::*;
#(
   parameter int unsigned MIN_GRN_CYC = MIN_GRN_CYC_DEF,
   parameter int unsigned MIN_YEL_CYC = MIN_YEL_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vld_i,
   input  logic       red_i,
   input  logic       yel_i,
   input  logic       grn_i,
   output logic [1:0] aspect_c_o,
   output logic       bad_c_o,
   output logic       illegal_seq_c_o,
   output logic       short_yel_c_o,
   output logic       short_grn_c_o,
   output logic       red_to_grn_c_o
);

   localparam int unsigned DWELL_MAX = (MIN_GRN_CYC > MIN_YEL_CYC) ? MIN_GRN_CYC : MIN_YEL_CYC;
   localparam int unsigned DW        = $clog2(DWELL_MAX + 1);

   aspect_e         aspect;
   aspect_e         prev_q, prev_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic            seeded_q, seeded_d;
   logic            changed;

   // Decode, violation flags and next history/dwell.
   always_comb begin
      aspect          = decode_aspect(red_i, yel_i, grn_i);
      changed         = seeded_q && (aspect != prev_q);
      prev_d          = prev_q;
      dwell_d         = dwell_q;
      seeded_d        = seeded_q;

      bad_c_o         = vld_i && (aspect == ASP_BAD);
      illegal_seq_c_o = vld_i && changed && !legal_step(prev_q, aspect);
      short_yel_c_o   = vld_i && changed && (prev_q == ASP_YEL) && (aspect == ASP_RED) &&
                        (dwell_q < DW'(MIN_YEL_CYC));
      short_grn_c_o   = vld_i && changed && (prev_q == ASP_GRN) && (aspect == ASP_YEL) &&
                        (dwell_q < DW'(MIN_GRN_CYC));
      red_to_grn_c_o  = vld_i && changed && (prev_q == ASP_RED) && (aspect == ASP_GRN);

      if (vld_i) begin
         prev_d   = aspect;
         seeded_d = 1'b1;
         // First sample after reset or an aspect change starts a new dwell at 1.
         if (!seeded_q || changed) begin
            dwell_d = DW'(1);
         end else if (dwell_q < DW'(DWELL_MAX)) begin
            dwell_d = dwell_q + DW'(1);
         end
      end
   end

   assign aspect_c_o = aspect;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= ASP_RED;
         dwell_q  <= '0;
         seeded_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         dwell_q  <= dwell_d;
         seeded_q <= seeded_d;
      end
   end

endmodule

// File: rtl/trsig_monitor.sv
// trsig_monitor: independent conflict/sequence monitor for a two-approach signal.
//   clk, rst                 : clock, synchronous active-high reset
//   reda, yela, grna         : approach A lamp drives
//   redb, yelb, grnb         : approach B lamp drives
//   fault                    : sticky violation flag
//   fault_code               : code of first violation, 0 when clear
//   flash                    : fail-safe flasher square wave while faulted
//   cyc_cnt                  : count of A RED->GRN steps, wraps at 256
module trsig_monitor
   import trsig_pkg::*;
#(
   parameter int unsigned MIN_GRN_CYC = MIN_GRN_CYC_DEF,
   parameter int unsigned MIN_YEL_CYC = MIN_YEL_CYC_DEF,
   parameter int unsigned FLASH_DIV   = FLASH_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reda,
   input  logic       yela,
   input  logic       grna,
   input  logic       redb,
   input  logic       yelb,
   input  logic       grnb,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash,
   output logic [7:0] cyc_cnt
);

   localparam int unsigned DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   logic [5:0]       s_lamps_q;
   logic             s_vld_q;

   logic [1:0]       asp_a_raw, asp_b_raw;
   aspect_e          asp_a, asp_b;
   logic             bad_a, bad_b, seq_a, seq_b;
   logic             syel_a, syel_b, sgrn_a, sgrn_b;
   logic             r2g_a, r2g_b_unused;
   logic             conflict_c;
   logic [2:0]       code_c;

   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic             flash_q, flash_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       cyc_q, cyc_d;

   trsig_aspect_chk #(.MIN_GRN_CYC(MIN_GRN_CYC), .MIN_YEL_CYC(MIN_YEL_CYC)) u_chk_a (
      .clk             (clk),
      .rst             (rst),
      .vld_i           (s_vld_q),
      .red_i           (s_lamps_q[5]),
      .yel_i           (s_lamps_q[4]),
      .grn_i           (s_lamps_q[3]),
      .aspect_c_o      (asp_a_raw),
      .bad_c_o         (bad_a),
      .illegal_seq_c_o (seq_a),
      .short_yel_c_o   (syel_a),
      .short_grn_c_o   (sgrn_a),
      .red_to_grn_c_o  (r2g_a)
   );

   trsig_aspect_chk #(.MIN_GRN_CYC(MIN_GRN_CYC), .MIN_YEL_CYC(MIN_YEL_CYC)) u_chk_b (
      .clk             (clk),
      .rst             (rst),
      .vld_i           (s_vld_q),
      .red_i           (s_lamps_q[2]),
      .yel_i           (s_lamps_q[1]),
      .grn_i           (s_lamps_q[0]),
      .aspect_c_o      (asp_b_raw),
      .bad_c_o         (bad_b),
      .illegal_seq_c_o (seq_b),
      .short_yel_c_o   (syel_b),
      .short_grn_c_o   (sgrn_b),
      .red_to_grn_c_o  (r2g_b_unused)
   );

   assign asp_a = aspect_e'(asp_a_raw);
   assign asp_b = aspect_e'(asp_b_raw);

   // Conflict check and priority encode, fault latch, flasher and cycle counter.
   always_comb begin
      conflict_c = s_vld_q &&
                   ((asp_a == ASP_YEL) || (asp_a == ASP_GRN)) &&
                   ((asp_b == ASP_YEL) || (asp_b == ASP_GRN));

      code_c = FC_NONE;
      if (conflict_c)           code_c = FC_CONFLICT;
      else if (bad_a || bad_b)  code_c = FC_ILLEGAL_ASP;
      else if (seq_a || seq_b)  code_c = FC_BAD_SEQ;
      else if (syel_a || syel_b) code_c = FC_SHORT_YEL;
      else if (sgrn_a || sgrn_b) code_c = FC_SHORT_GRN;

      fault_d = fault_q;
      code_d  = code_q;
      flash_d = flash_q;
      div_d   = div_q;
      cyc_d   = cyc_q;

      if (fault_q) begin
         if (div_q == DIV_W'(FLASH_DIV - 1)) begin
            div_d   = '0;
            flash_d = ~flash_q;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else if (code_c != FC_NONE) begin
         // Flasher starts lit on the cycle the fault is latched.
         fault_d = 1'b1;
         code_d  = code_c;
         flash_d = 1'b1;
         div_d   = '0;
      end

      if (r2g_a) cyc_d = cyc_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_lamps_q <= '0;
         s_vld_q   <= 1'b0;
         fault_q   <= 1'b0;
         code_q    <= FC_NONE;
         flash_q   <= 1'b0;
         div_q     <= '0;
         cyc_q     <= '0;
      end else begin
         s_lamps_q <= {reda, yela, grna, redb, yelb, grnb};
         s_vld_q   <= 1'b1;
         fault_q   <= fault_d;
         code_q    <= code_d;
         flash_q   <= flash_d;
         div_q     <= div_d;
         cyc_q     <= cyc_d;
      end
   end

   assign fault      = fault_q;
   assign fault_code = code_q;
   assign flash      = flash_q;
   assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_trsig_monitor.sv
// tb_trsig_monitor: directed and randomized bench for trsig_monitor against a
// sample-history reference model.
module tb_trsig_monitor;

   localparam int MIN_G = 5;
   localparam int MIN_Y = 3;
   localparam int FDIV  = 4;
   localparam int R = 0, Y = 1, G = 2, X = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reda = 1'b0, yela = 1'b0, grna = 1'b0;
   logic       redb = 1'b0, yelb = 1'b0, grnb = 1'b0;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash;
   logic [7:0] cyc_cnt;

   always #5 clk = ~clk;

   trsig_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .reda       (reda),
      .yela       (yela),
      .grna       (grna),
      .redb       (redb),
      .yelb       (yelb),
      .grnb       (grnb),
      .fault      (fault),
      .fault_code (fault_code),
      .flash      (flash),
      .cyc_cnt    (cyc_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: last registered sample plus per-approach history.
   bit         m_vld, m_seed, m_fault;
   logic [5:0] m_lamps;
   int         m_prev_a, m_prev_b, m_run_a, m_run_b;
   int         m_code, m_t, m_cyc;

   function automatic int asp_of(input logic [2:0] ryg);
      if ($countones(ryg) != 1) return X;
      if (ryg[2]) return R;
      if (ryg[1]) return Y;
      return G;
   endfunction

   function automatic logic [2:0] lamps_of(input int a);
      logic [2:0] bad_tab [5];
      bad_tab = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};
      case (a)
         R:       return 3'b100;
         Y:       return 3'b010;
         G:       return 3'b001;
         default: return bad_tab[$urandom_range(0, 4)];
      endcase
   endfunction

   function automatic int trans_code(input int p, input int c, input int run);
      if (p == c) return 0;
      if (!((p == G && c == Y) || (p == Y && c == R) || (p == R && c == G))) return 3;
      if (p == Y && c == R && run < MIN_Y) return 4;
      if (p == G && c == Y && run < MIN_G) return 5;
      return 0;
   endfunction

   function automatic int pick(input int best, input int c);
      if (c != 0 && (best == 0 || c < best)) return c;
      return best;
   endfunction

   task automatic model_step(input bit r, input logic [5:0] lamps);
      int a, b, best;
      if (r) begin
         m_vld = 0; m_seed = 0; m_fault = 0; m_lamps = '0;
         m_prev_a = R; m_prev_b = R; m_run_a = 0; m_run_b = 0;
         m_code = 0; m_t = 0; m_cyc = 0;
      end else begin
         if (m_vld) begin
            a = asp_of(m_lamps[5:3]);
            b = asp_of(m_lamps[2:0]);
            best = 0;
            if ((a == Y || a == G) && (b == Y || b == G)) best = pick(best, 1);
            if (a == X || b == X) best = pick(best, 2);
            if (m_seed) begin
               best = pick(best, trans_code(m_prev_a, a, m_run_a));
               best = pick(best, trans_code(m_prev_b, b, m_run_b));
               if (m_prev_a == R && a == G) m_cyc++;
            end
            if (m_fault) m_t++;
            else if (best != 0) begin
               m_fault = 1; m_code = best; m_t = 0;
            end
            m_run_a = (!m_seed || a != m_prev_a) ? 1 : m_run_a + 1;
            m_run_b = (!m_seed || b != m_prev_b) ? 1 : m_run_b + 1;
            m_prev_a = a;
            m_prev_b = b;
            m_seed = 1;
         end
         m_vld = 1;
         m_lamps = lamps;
      end
   endtask

   task automatic tick(input bit r, input logic [5:0] lamps);
      rst = r;
      {reda, yela, grna, redb, yelb, grnb} = lamps;
      @(posedge clk);
      model_step(r, lamps);
      #1;
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_code", 32'(fault_code), 32'(m_code));
      check("flash", 32'(flash), 32'(m_fault && ((m_t / FDIV) % 2 == 0)));
      check("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc % 256));
   endtask

   task automatic hold(input int a, input int b, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, {lamps_of(a), lamps_of(b)});
   endtask

   task automatic do_reset();
      tick(1'b1, {3'b100, 3'b100});
      tick(1'b1, {3'b100, 3'b100});
   endtask

   initial begin
      int ga, ya, gb, yb;

      // Reset state
      do_reset();
      check("rst_fault", 32'(fault), 0);
      check("rst_code", 32'(fault_code), 0);
      check("rst_flash", 32'(flash), 0);
      check("rst_cyc", 32'(cyc_cnt), 0);

      // Legal sequence, 300 A cycles, counter wraps
      hold(R, R, 1);
      for (int i = 0; i < 300; i++) begin
         hold(G, R, 5); hold(Y, R, 3); hold(R, G, 5); hold(R, Y, 3);
      end
      hold(R, R, 2);
      check("legal_cyc_final", 32'(cyc_cnt), 44);
      check("legal_no_fault", 32'(fault), 0);

      // Conflict: one-cycle double green, latency and flash cadence
      do_reset();
      hold(R, R, 3);
      tick(1'b0, {3'b001, 3'b001});
      check("conf_lat_before", 32'(fault), 0);
      hold(R, R, 1);
      check("conf_fault", 32'(fault), 1);
      check("conf_code", 32'(fault_code), 1);
      check("conf_flash_start", 32'(flash), 1);
      hold(R, R, 3);
      check("conf_flash_hold", 32'(flash), 1);
      hold(R, R, 1);
      check("conf_flash_low", 32'(flash), 0);
      hold(R, R, 4);
      check("conf_flash_high2", 32'(flash), 1);

      // Sticky: short yellow after conflict keeps code 1
      hold(R, R, 2); hold(G, R, 5); hold(Y, R, 2); hold(R, R, 2);
      check("sticky_code", 32'(fault_code), 1);

      // One-cycle reset pulse clears, legal run stays clean
      tick(1'b1, {3'b100, 3'b100});
      check("pulse_fault", 32'(fault), 0);
      check("pulse_code", 32'(fault_code), 0);
      check("pulse_flash", 32'(flash), 0);
      check("pulse_cyc", 32'(cyc_cnt), 0);
      hold(R, R, 1);
      for (int i = 0; i < 3; i++) begin
         hold(G, R, 5); hold(Y, R, 3); hold(R, G, 5); hold(R, Y, 3);
      end
      hold(R, R, 2);
      check("pulse_legal_fault", 32'(fault), 0);
      check("pulse_legal_cyc", 32'(cyc_cnt), 3);

      // Priority: A GRN->RED while B dark -> illegal aspect wins
      do_reset();
      hold(R, R, 1); hold(G, R, 5);
      tick(1'b0, {3'b100, 3'b000});
      hold(R, R, 2);
      check("prio_code", 32'(fault_code), 2);

      // Short yellow (2) faults, yellow of 3 does not
      do_reset();
      hold(R, R, 1); hold(G, R, 5); hold(Y, R, 2); hold(R, R, 2);
      check("short_yel_code", 32'(fault_code), 4);
      do_reset();
      hold(R, R, 1); hold(G, R, 5); hold(Y, R, 3); hold(R, R, 2);
      check("yel3_no_fault", 32'(fault), 0);

      // Short green
      do_reset();
      hold(R, R, 1); hold(G, R, 4); hold(Y, R, 3); hold(R, R, 2);
      check("short_grn_code", 32'(fault_code), 5);

      // Violating pattern on the seed sample
      do_reset();
      tick(1'b0, {3'b010, 3'b001});
      hold(R, R, 2);
      check("seed_conf_code", 32'(fault_code), 1);

      // Randomized runs with glitches and mid-run resets
      for (int round = 0; round < 40; round++) begin
         do_reset();
         hold(R, R, $urandom_range(1, 2));
         for (int ph = 0; ph < 8; ph++) begin
            ga = $urandom_range(3, 7); ya = $urandom_range(1, 4);
            gb = $urandom_range(3, 7); yb = $urandom_range(1, 4);
            hold(G, R, ga); hold(Y, R, ya);
            if ($urandom_range(0, 9) == 0) tick(1'b0, 6'($urandom()));
            hold(R, G, gb); hold(R, Y, yb);
            if ($urandom_range(0, 29) == 0) tick(1'b1, {3'b100, 3'b100});
            if ($urandom_range(0, 14) == 0) hold($urandom_range(0, 3), $urandom_range(0, 3), 1);
            hold(R, R, $urandom_range(1, 2));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trsig_monitor.md
# trsig_monitor

Independent conflict monitor for the two-approach traffic signal controller: it receives the six lamp drives (red/yellow/green for approaches A and B) and checks them every clock for unsafe or out-of-sequence aspects. On the first violation it latches a sticky fault with a code and drives a flash command for the cabinet's fail-safe flasher. It sits beside the controller on the same clock, reading the controller's outputs only, and never feeds back into the controller.

## Interface
Parameters:
- MIN_GRN_CYC, 5: minimum consecutive sampled cycles of green before yellow is legal.
- MIN_YEL_CYC, 3: minimum consecutive sampled cycles of yellow before red is legal.
- FLASH_DIV, 4: cycles per flash half-period while faulted.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- reda, yela, grna  in  1 each  approach A lamp drives, active-high.
- redb, yelb, grnb  in  1 each  approach B lamp drives, active-high.
- fault  out  1  sticky violation flag.
- fault_code  out  3  code of the first violation; 0 when no fault.
- flash  out  1  square wave while faulted; 0 otherwise.
- cyc_cnt  out  8  completed A-green starts, counts RED->GRN on A, wraps 255->0.

## Operation
- Stage 1: register all six lamp inputs once (s_*).
- Per approach, decode the sampled lamps into an aspect:
  - RED, YEL, or GRN when exactly one lamp is lit.
  - BAD when no lamp or more than one lamp is lit.
- Per approach, keep the previous aspect and a dwell counter.
  - Dwell counts consecutive samples of the current aspect; the first sample is 1.
  - Dwell saturates at max(MIN_GRN_CYC, MIN_YEL_CYC).
  - Dwell reloads to 1 on any aspect change.
- Legal transitions: self, GRN->YEL, YEL->RED, RED->GRN. Any other change is a sequence violation.
- The first valid sample after reset seeds the previous aspect; no transition check is made on that sample.
- Violation checks, in priority order (lowest code wins when several fire on the same sample):
  - 1 CONFLICT: neither approach is RED, with both aspects in {YEL, GRN}.
  - 2 ILLEGAL_ASPECT: either approach is BAD.
  - 3 BAD_SEQUENCE: illegal transition on either approach.
  - 4 SHORT_YELLOW: YEL->RED with dwell < MIN_YEL_CYC.
  - 5 SHORT_GREEN: GRN->YEL with dwell < MIN_GRN_CYC.
- Fault latching:
  - The first violation sets fault=1 and fault_code to its code.
  - Both hold until rst; later violations are ignored.
  - Checking and cyc_cnt continue while faulted.
- Flash: while fault=1, a divider toggles flash every FLASH_DIV cycles, starting at 1 on the cycle fault rises.

## Timing
- Reset values: fault=0, fault_code=0, flash=0, cyc_cnt=0. Stage-1 registers, aspect history and dwell counters are cleared; the seed flag is cleared.
- Latency: a lamp value present at rising edge N is sampled at edge N. fault and fault_code update at edge N+1.
- cyc_cnt increments at edge N+1 for an A RED->GRN sampled at edge N.
- Reset mid-fault:
  - Clears everything at that edge.
  - The first sample after rst deasserts re-seeds the history.
  - A lamp pattern that remains violating is re-flagged one cycle later; a violating pattern on the seed sample is flagged in the same way.
  - Transition-based codes (3-5) need two samples after reset.
- Simultaneous transitions on A and B are each checked independently on the same sample.

## Structure
- Package trsig_pkg holds:
  - The aspect enum (RED, YEL, GRN, BAD).
  - The fault-code constants (FC_NONE=0 … FC_SHORT_GRN=5).
  - Defaults for the minimum dwell times; the controller shares these.
- Sub-module trsig_aspect_chk, instantiated once per approach, contains:
  - The decode, previous-aspect register and saturating dwell counter.
  - Flags: bad, illegal_seq, short_yel, short_grn, red_to_grn.
- The top level contains the stage-1 registers, conflict check, priority encoder, fault latch, flash divider and cyc_cnt.

## Test plan
- Legal sequence: A GRN 5 / YEL 3 / RED while B is RED, then mirrored, for 300 A cycles -> fault=0 throughout; cyc_cnt wraps and ends at 300 mod 256 = 44.
- Conflict: grna=1 and grnb=1 for one cycle -> fault=1, fault_code=1 two edges later; flash toggles every 4 cycles.
- Priority: A jumps GRN->RED while B shows no lamp on the same sample -> fault_code=2, not 3.
- Short yellow: A yellow held for 2 cycles, then red -> fault_code=4. Held for 3 cycles -> no fault.
- Short green: A green for 4 cycles, then yellow -> fault_code=5.
- Sticky fault and reset: after fault_code=1, inject a short-yellow violation -> code stays 1. Pulse rst for one cycle -> all outputs 0; the lamps resume a legal sequence with no fault.
